// File: rtl/serial_to_parallel_stream.sv
// Lane-serial to word deserializer with ready/valid on both sides.
// Beats pack LSB-first or MSB-first; serial_last flushes a partial word.
module serial_to_parallel_stream #(
  parameter int width     = 8,
  parameter int lanes     = 1,
  parameter int msb_first = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_valid,
  output logic                       serial_ready,
  input  logic [lanes-1:0]           serial_data,
  input  logic                       serial_last,
  output logic                       parallel_valid,
  input  logic                       parallel_ready,
  output logic [width-1:0]           parallel_data,
  output logic [$clog2(width+1)-1:0] parallel_count
);

  localparam int beats = width / lanes;
  localparam int kw    = (beats > 1) ? $clog2(beats) : 1;
  localparam int cw    = $clog2(width + 1);

  logic [width-1:0] acc;
  logic [kw-1:0]    k;
  logic [width-1:0] merged;
  logic [cw-1:0]    count_next;
  logic             accept;
  logic             complete;

  assign serial_ready = ~rst & (~parallel_valid | parallel_ready);
  assign accept       = serial_valid & serial_ready;
  assign complete     = accept & (serial_last | (k == kw'(beats - 1)));

  // Accumulator with the current beat dropped into slot k.
  always_comb begin
    merged     = acc;
    count_next = '0;
    for (int i = 0; i < beats; i++) begin
      if (k == kw'(i)) begin
        if (msb_first != 0) merged[width-(i+1)*lanes +: lanes] = serial_data;
        else                merged[i*lanes +: lanes]           = serial_data;
        count_next = cw'((i + 1) * lanes);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc            <= '0;
      k              <= '0;
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
      parallel_count <= '0;
    end else if (complete) begin
      // A new word wins over the handshake drop on the same edge.
      parallel_data  <= merged;
      parallel_count <= count_next;
      parallel_valid <= 1'b1;
      acc            <= '0;
      k              <= '0;
    end else begin
      if (accept) begin
        acc <= merged;
        k   <= k + kw'(1);
      end
      if (parallel_valid && parallel_ready) parallel_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Directed bench: three instances cover LSB-first, MSB-first and two-lane packing.
module tb_serial_to_parallel_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       sv = 1'b0, sl = 1'b0, pr = 1'b1;
  logic [0:0] sd = '0;
  logic       sr0, pv0, sr1, pv1;
  logic [7:0] pd0, pd1;
  logic [3:0] pc0, pc1;

  logic       sv2 = 1'b0, sl2 = 1'b0, pr2 = 1'b1;
  logic [1:0] sd2 = '0;
  logic       sr2, pv2;
  logic [7:0] pd2;
  logic [3:0] pc2;

  int vectors = 0;
  int miscompares = 0;
  int valid_seen;
  logic [7:0] w;

  always #5 clk = ~clk;

  serial_to_parallel_stream #(.width(8), .lanes(1), .msb_first(0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_valid(sv), .serial_ready(sr0), .serial_data(sd),
    .serial_last(sl), .parallel_valid(pv0), .parallel_ready(pr),
    .parallel_data(pd0), .parallel_count(pc0));

  serial_to_parallel_stream #(.width(8), .lanes(1), .msb_first(1)) dut_msb (
    .clk(clk), .rst(rst), .serial_valid(sv), .serial_ready(sr1), .serial_data(sd),
    .serial_last(sl), .parallel_valid(pv1), .parallel_ready(pr),
    .parallel_data(pd1), .parallel_count(pc1));

  serial_to_parallel_stream #(.width(8), .lanes(2), .msb_first(0)) dut_l2 (
    .clk(clk), .rst(rst), .serial_valid(sv2), .serial_ready(sr2), .serial_data(sd2),
    .serial_last(sl2), .parallel_valid(pv2), .parallel_ready(pr2),
    .parallel_data(pd2), .parallel_count(pc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic b, input logic l);
    sv = 1'b1; sd = b; sl = l;
    step();
  endtask

  task automatic send2(input logic [1:0] b, input logic l);
    sv2 = 1'b1; sd2 = b; sl2 = l;
    step();
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, pv0}, 32'd0);
    chk("rst_data", {24'd0, pd0}, 32'd0);
    chk("rst_count", {28'd0, pc0}, 32'd0);
    chk("rst_ready", {31'd0, sr0}, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, sr0}, 32'd1);

    // LSB-first and MSB-first word from bits 1,0,1,1,0,0,1,0
    w = 8'b0100_1101;
    for (int i = 0; i < 7; i++) send1(w[i], 1'b0);
    chk("no_valid_at_7", {31'd0, pv0}, 32'd0);
    send1(w[7], 1'b0);
    sv = 1'b0;
    chk("t1_valid", {31'd0, pv0}, 32'd1);
    chk("t1_data", {24'd0, pd0}, 32'h4D);
    chk("t1_count", {28'd0, pc0}, 32'd8);
    chk("t2_data_msb", {24'd0, pd1}, 32'hB2);
    chk("t2_count_msb", {28'd0, pc1}, 32'd8);
    step();
    chk("t1_valid_drop", {31'd0, pv0}, 32'd0);

    // Flush after three ones
    send1(1'b1, 1'b0); send1(1'b1, 1'b0); send1(1'b1, 1'b1);
    sv = 1'b0; sl = 1'b0;
    chk("t4_data_lsb", {24'd0, pd0}, 32'h07);
    chk("t4_count_lsb", {28'd0, pc0}, 32'd3);
    chk("t4_data_msb", {24'd0, pd1}, 32'hE0);
    chk("t4_count_msb", {28'd0, pc1}, 32'd3);
    step();

    // Backpressure: hold 4D for five cycles with the next beat waiting
    pr = 1'b0;
    for (int i = 0; i < 8; i++) send1(w[i], 1'b0);
    chk("t5_valid", {31'd0, pv0}, 32'd1);
    w = 8'hA5;
    sv = 1'b1; sd = w[0]; sl = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_data", {24'd0, pd0}, 32'h4D);
      chk("t5_hold_ready", {31'd0, sr0}, 32'd0);
      step();
    end
    chk("t5_hold_valid", {31'd0, pv0}, 32'd1);
    pr = 1'b1;
    step();
    chk("t5_consumed", {31'd0, pv0}, 32'd0);
    for (int i = 1; i < 8; i++) send1(w[i], (i == 7));
    sl = 1'b0;
    chk("t5_next_data", {24'd0, pd0}, 32'hA5);
    chk("t5_last_full_count", {28'd0, pc0}, 32'd8);
    chk("t5_next_data_msb", {24'd0, pd1}, 32'hA5);

    // Back-to-back words 3C then C3 with ready held high
    valid_seen = 0;
    for (int j = 0; j < 16; j++) begin
      w = (j < 8) ? 8'h3C : 8'hC3;
      send1(w[j % 8], 1'b0);
      if (pv0) valid_seen++;
      chk("t5_b2b_ready", {31'd0, sr0}, 32'd1);
      if (j == 7)  chk("t5_b2b_word0", {24'd0, pd0}, 32'h3C);
      if (j == 15) chk("t5_b2b_word1", {24'd0, pd0}, 32'hC3);
    end
    chk("t5_b2b_valid_count", valid_seen, 32'd2);

    // Reset mid-word
    for (int i = 0; i < 4; i++) send1(1'b1, 1'b0);
    sv = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, pv0}, 32'd0);
    chk("t6_data", {24'd0, pd0}, 32'd0);
    chk("t6_count", {28'd0, pc0}, 32'd0);
    chk("t6_ready", {31'd0, sr0}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send1(1'b1, 1'b0);
    chk("t6_no_stale_word", {31'd0, pv0}, 32'd0);
    for (int i = 0; i < 4; i++) send1(1'b1, 1'b0);
    sv = 1'b0;
    chk("t6_data_ff", {24'd0, pd0}, 32'hFF);
    chk("t6_count_ff", {28'd0, pc0}, 32'd8);
    step();

    // Two lanes: 01,10,11,00
    send2(2'b01, 1'b0); send2(2'b10, 1'b0); send2(2'b11, 1'b0);
    chk("t3_no_valid_at_3", {31'd0, pv2}, 32'd0);
    send2(2'b00, 1'b0);
    sv2 = 1'b0;
    chk("t3_valid", {31'd0, pv2}, 32'd1);
    chk("t3_data", {24'd0, pd2}, 32'h39);
    chk("t3_count", {28'd0, pc2}, 32'd8);
    step();
    send2(2'b11, 1'b1);
    sv2 = 1'b0; sl2 = 1'b0;
    chk("t3_flush_data", {24'd0, pd2}, 32'h03);
    chk("t3_flush_count", {28'd0, pc2}, 32'd2);
    // Last on a refused beat must be ignored
    pr2 = 1'b0;
    sv2 = 1'b1; sd2 = 2'b10; sl2 = 1'b1;
    step();
    chk("t3_refused_hold", {24'd0, pd2}, 32'h03);
    sv2 = 1'b0; sl2 = 1'b0; pr2 = 1'b1;
    step();
    chk("t3_refused_drop", {31'd0, pv2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
